// File: rtl/al_retire_ctrl_pkg.sv
// Shared sizing, FSM state type and retire-lane payload for the active-list retire controller.
package al_retire_ctrl_pkg;

   localparam int unsigned AL_RPORT  = 4;
   localparam int unsigned AL_WPORT  = 4;
   localparam int unsigned AL_DEPTH  = 16;
   localparam int unsigned AL_INDEX  = 4;
   localparam int unsigned AL_WIDTH  = 8;
   localparam int unsigned AL_CNT_W  = AL_INDEX + 1;
   localparam int unsigned AL_DISP_W = $clog2(AL_WPORT + 1);
   localparam int unsigned AL_LANE_W = $clog2(AL_RPORT + 1);

   // Pointer arithmetic wraps naturally only when the list is a power-of-two deep.
   localparam bit AL_DEPTH_OK = (AL_DEPTH == (32'd1 << AL_INDEX));

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      EXCEPT = 2'd1,
      FLUSH  = 2'd2
   } al_state_e;

   typedef struct packed {
      logic                valid;
      logic [AL_WIDTH-1:0] data;
   } al_lane_t;

endpackage

// File: rtl/al_retire_ctrl_ready_scan.sv
// Counts the leading completed, non-faulting lanes from the head and flags a faulted head entry.
module al_ready_scan
   import al_retire_ctrl_pkg::*;
(
   input  logic [AL_RPORT-1:0]  done,
   input  logic [AL_RPORT-1:0]  exc,
   input  logic [AL_LANE_W-1:0] limit,
   output logic [AL_LANE_W-1:0] k_c,
   output logic                 head_exc_c
);

   logic stop;

   always_comb begin
      k_c  = '0;
      stop = 1'b0;
      for (int i = 0; i < AL_RPORT; i++) begin
         if (!stop && (AL_LANE_W'(i) < limit) && done[i] && !exc[i]) begin
            k_c = AL_LANE_W'(i + 1);
         end else begin
            stop = 1'b1;
         end
      end
      head_exc_c = (limit != '0) && done[0] && exc[0];
   end

endmodule

// File: rtl/al_retire_ctrl.sv
// In-order retire controller: owns head/count, retires contiguous done entries, sequences exception flush.
// Optional retired-lane counter port enabled by defining ALRETIRE_PERF_CNT_EN.
module al_retire_ctrl
   import al_retire_ctrl_pkg::*;
(
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [AL_DISP_W-1:0]              dispatch_cnt_i,
   input  logic [AL_DEPTH-1:0]               done_vec_i,
   input  logic [AL_DEPTH-1:0]               exc_vec_i,
   output logic [AL_RPORT-1:0][AL_INDEX-1:0] rd_addr_o,
   input  logic [AL_RPORT-1:0][AL_WIDTH-1:0] rd_data_i,
   output logic [AL_RPORT-1:0]               retire_valid_o,
   output logic [AL_RPORT-1:0][AL_WIDTH-1:0] retire_data_o,
   input  logic                              retire_ready_i,
   output logic                              exception_o,
   output logic [AL_WIDTH-1:0]               exc_data_o,
   output logic [AL_INDEX-1:0]               head_o,
   output logic [AL_CNT_W-1:0]               count_o,
   output logic                              full_o,
   output logic                              empty_o,
   output logic                              ovf_o
`ifdef ALRETIRE_PERF_CNT_EN
   ,
   output logic [31:0]                       retired_cnt_o
`endif
);

   localparam int unsigned SUM_W = AL_CNT_W + 1;

   if (!AL_DEPTH_OK) begin : g_depth_chk
      $error("al_retire_ctrl: DEPTH must equal 2**INDEX");
   end

   al_state_e                state_q, state_d;
   logic [AL_INDEX-1:0]      head_q, head_d;
   logic [AL_CNT_W-1:0]      count_q, count_d;
   al_lane_t [AL_RPORT-1:0]  lane_q, lane_d;
   logic                     exc_q, exc_d;
   logic [AL_WIDTH-1:0]      exc_data_q, exc_data_d;
   logic                     full_q, empty_q, ovf_q, ovf_set;
   logic [AL_RPORT-1:0]      lane_done, lane_exc, valid_vec;
   logic [AL_LANE_W-1:0]     limit, scan_k, k_eff;
   logic                     head_exc, out_free;
   logic [AL_DISP_W-1:0]     disp_eff;
   logic [SUM_W-1:0]         sum;

   // Read lanes walk forward from the head and wrap through the pointer width.
   always_comb begin
      for (int i = 0; i < AL_RPORT; i++) begin
         rd_addr_o[i]     = head_q + AL_INDEX'(i);
         lane_done[i]     = done_vec_i[rd_addr_o[i]];
         lane_exc[i]      = exc_vec_i[rd_addr_o[i]];
         valid_vec[i]     = lane_q[i].valid;
         retire_data_o[i] = lane_q[i].data;
      end
   end

   assign limit    = (count_q >= AL_CNT_W'(AL_RPORT)) ? AL_LANE_W'(AL_RPORT) : AL_LANE_W'(count_q);
   assign out_free = (valid_vec == '0) || retire_ready_i;

   al_ready_scan u_scan (
      .done       (lane_done),
      .exc        (lane_exc),
      .limit      (limit),
      .k_c        (scan_k),
      .head_exc_c (head_exc)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= RUN;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (head_exc) state_d = EXCEPT;
         EXCEPT:  if (out_free) state_d = FLUSH;
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      k_eff      = '0;
      lane_d     = lane_q;
      exc_d      = 1'b0;
      exc_data_d = exc_data_q;
      disp_eff   = dispatch_cnt_i;
      case (state_q)
         RUN: begin
            if (out_free) begin
               k_eff = scan_k;
               for (int i = 0; i < AL_RPORT; i++) begin
                  lane_d[i] = '0;
                  if (AL_LANE_W'(i) < scan_k) begin
                     lane_d[i].valid = 1'b1;
                     lane_d[i].data  = rd_data_i[i];
                  end
               end
            end
         end
         EXCEPT: begin
            // The faulted entry stays at the head until the pending group drains.
            if (out_free) begin
               lane_d     = '0;
               exc_d      = 1'b1;
               exc_data_d = rd_data_i[0];
            end
         end
         default: disp_eff = '0;
      endcase

      sum     = SUM_W'(count_q) + SUM_W'(disp_eff) - SUM_W'(k_eff);
      ovf_set = (sum > SUM_W'(AL_DEPTH));
      count_d = ovf_set ? AL_CNT_W'(AL_DEPTH) : AL_CNT_W'(sum);
      head_d  = head_q + AL_INDEX'(k_eff);
      if (state_q == FLUSH) begin
         head_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q     <= '0;
         count_q    <= '0;
         lane_q     <= '0;
         exc_q      <= 1'b0;
         exc_data_q <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         ovf_q      <= 1'b0;
      end else begin
         head_q     <= head_d;
         count_q    <= count_d;
         lane_q     <= lane_d;
         exc_q      <= exc_d;
         exc_data_q <= exc_data_d;
         full_q     <= (count_d == AL_CNT_W'(AL_DEPTH));
         empty_q    <= (count_d == '0);
         ovf_q      <= ovf_q | ovf_set;
      end
   end

   assign retire_valid_o = valid_vec;
   assign exception_o    = exc_q;
   assign exc_data_o     = exc_data_q;
   assign head_o         = head_q;
   assign count_o        = count_q;
   assign full_o         = full_q;
   assign empty_o        = empty_q;
   assign ovf_o          = ovf_q;

`ifdef ALRETIRE_PERF_CNT_EN
   logic [31:0]          retired_cnt_q;
   logic [AL_LANE_W-1:0] acc_c;

   // Lanes leaving the output register this cycle; survives flush.
   always_comb begin
      acc_c = '0;
      for (int i = 0; i < AL_RPORT; i++) begin
         if (retire_ready_i && valid_vec[i]) acc_c = acc_c + AL_LANE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) retired_cnt_q <= '0;
      else          retired_cnt_q <= retired_cnt_q + 32'(acc_c);
   end

   assign retired_cnt_o = retired_cnt_q;
`endif

endmodule

// File: tb/tb_al_retire_ctrl.sv
// Bench for al_retire_ctrl: directed scenarios, a queue-level reference model checked every cycle.
module tb_al_retire_ctrl;
   import al_retire_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                              reset_n;
   logic [AL_DISP_W-1:0]              dispatch_cnt_i;
   logic [AL_DEPTH-1:0]               done_vec_i, exc_vec_i;
   logic [AL_RPORT-1:0][AL_INDEX-1:0] rd_addr_o;
   logic [AL_RPORT-1:0][AL_WIDTH-1:0] rd_data_i;
   logic [AL_RPORT-1:0]               retire_valid_o;
   logic [AL_RPORT-1:0][AL_WIDTH-1:0] retire_data_o;
   logic                              retire_ready_i;
   logic                              exception_o;
   logic [AL_WIDTH-1:0]               exc_data_o;
   logic [AL_INDEX-1:0]               head_o;
   logic [AL_CNT_W-1:0]               count_o;
   logic                              full_o, empty_o, ovf_o;
`ifdef ALRETIRE_PERF_CNT_EN
   logic [31:0]                       retired_cnt_o;
`endif

   al_retire_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .dispatch_cnt_i (dispatch_cnt_i),
      .done_vec_i     (done_vec_i),
      .exc_vec_i      (exc_vec_i),
      .rd_addr_o      (rd_addr_o),
      .rd_data_i      (rd_data_i),
      .retire_valid_o (retire_valid_o),
      .retire_data_o  (retire_data_o),
      .retire_ready_i (retire_ready_i),
      .exception_o    (exception_o),
      .exc_data_o     (exc_data_o),
      .head_o         (head_o),
      .count_o        (count_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .ovf_o          (ovf_o)
`ifdef ALRETIRE_PERF_CNT_EN
      ,
      .retired_cnt_o  (retired_cnt_o)
`endif
   );

   // Active-list payload RAM, read combinationally at the DUT's addresses.
   logic [7:0] mem [16];
   always_comb begin
      for (int i = 0; i < 4; i++) rd_data_i[i] = mem[rd_addr_o[i]];
   end

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;
   int tail     = 0;

   // Reference model: occupancy as integers, output group as a lane count plus payload list.
   int          m_head, m_count, m_vcnt, m_phase;
   logic [7:0]  m_vdata [4];
   bit          m_exc, m_ovf;
   logic [7:0]  m_exc_data;
   int unsigned m_retired;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int k, n, nxt, disp, total;
      bit free, fault;
      if (!reset_n) begin
         m_head = 0; m_count = 0; m_vcnt = 0; m_phase = 0;
         m_exc = 0; m_exc_data = 8'h00; m_ovf = 0; m_retired = 0;
         for (int j = 0; j < 4; j++) m_vdata[j] = 8'h00;
         return;
      end
      free = (m_vcnt == 0) || retire_ready_i;
      if (retire_ready_i) m_retired += m_vcnt;
      k = 0; nxt = m_phase; disp = int'(dispatch_cnt_i); m_exc = 0;
      case (m_phase)
         0: begin
            n = (m_count < 4) ? m_count : 4;
            while (k < n && done_vec_i[(m_head + k) % 16] && !exc_vec_i[(m_head + k) % 16]) k++;
            fault = (m_count > 0) && done_vec_i[m_head] && exc_vec_i[m_head];
            if (free) begin
               m_vcnt = k;
               for (int j = 0; j < 4; j++) m_vdata[j] = (j < k) ? mem[(m_head + j) % 16] : 8'h00;
            end else begin
               k = 0;
            end
            if (fault) nxt = 1;
         end
         1: begin
            if (free) begin
               m_vcnt = 0;
               for (int j = 0; j < 4; j++) m_vdata[j] = 8'h00;
               m_exc = 1;
               m_exc_data = mem[m_head];
               nxt = 2;
            end
         end
         default: begin
            disp = 0;
            nxt = 0;
         end
      endcase
      total = m_count + disp - k;
      if (total > 16) begin
         m_ovf = 1;
         total = 16;
      end
      m_count = total;
      m_head  = (m_head + k) % 16;
      if (m_phase == 2) begin
         m_head = 0;
         m_count = 0;
      end
      m_phase = nxt;
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin : cmp
      logic [3:0] ev;
      if (cmp_en) begin
         ev = 4'((1 << m_vcnt) - 1);
         chk("valid", 64'(retire_valid_o), 64'(ev));
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("data%0d", i), 64'(retire_data_o[i]), 64'(m_vdata[i]));
            chk($sformatf("rd_addr%0d", i), 64'(rd_addr_o[i]), 64'((m_head + i) % 16));
         end
         chk("exception", 64'(exception_o), 64'(m_exc));
         if (m_exc) chk("exc_data", 64'(exc_data_o), 64'(m_exc_data));
         chk("head", 64'(head_o), 64'(m_head));
         chk("count", 64'(count_o), 64'(m_count));
         chk("full", 64'(full_o), 64'(m_count == 16));
         chk("empty", 64'(empty_o), 64'(m_count == 0));
         chk("ovf", 64'(ovf_o), 64'(m_ovf));
`ifdef ALRETIRE_PERF_CNT_EN
         chk("retired_cnt", 64'(retired_cnt_o), 64'(m_retired));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input int n, input logic [7:0] base, input bit dn, input bit ex);
      for (int j = 0; j < n; j++) begin
         mem[(tail + j) % 16]        = base + 8'(j);
         done_vec_i[(tail + j) % 16] = dn;
         exc_vec_i[(tail + j) % 16]  = ex;
      end
      dispatch_cnt_i = AL_DISP_W'(n);
      tail = (tail + n) % 16;
      tick();
      dispatch_cnt_i = '0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 64'(retire_valid_o), 64'(0));
      chk({tag, "_data"}, 64'(retire_data_o), 64'(0));
      chk({tag, "_exception"}, 64'(exception_o), 64'(0));
      chk({tag, "_exc_data"}, 64'(exc_data_o), 64'(0));
      chk({tag, "_head"}, 64'(head_o), 64'(0));
      chk({tag, "_count"}, 64'(count_o), 64'(0));
      chk({tag, "_empty"}, 64'(empty_o), 64'(1));
      chk({tag, "_full"}, 64'(full_o), 64'(0));
      chk({tag, "_ovf"}, 64'(ovf_o), 64'(0));
`ifdef ALRETIRE_PERF_CNT_EN
      chk({tag, "_retired_cnt"}, 64'(retired_cnt_o), 64'(0));
`endif
   endtask

   initial begin
      reset_n = 1'b0;
      dispatch_cnt_i = '0;
      done_vec_i = '0;
      exc_vec_i = '0;
      retire_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      tick();
      tick();
      cmp_en = 1'b1;
      chk_reset_vals("reset");
      reset_n = 1'b1;

      // Partial completion: slots 0,1,3 done, slot 2 blocks the rest.
      dispatch(4, 8'h10, 1'b0, 1'b0);
      chk("t1_count_disp", 64'(count_o), 64'(4));
      done_vec_i[0] = 1'b1; done_vec_i[1] = 1'b1; done_vec_i[3] = 1'b1;
      tick();
      chk("t1_valid", 64'(retire_valid_o), 64'(4'b0011));
      chk("t1_data0", 64'(retire_data_o[0]), 64'(8'h10));
      chk("t1_data1", 64'(retire_data_o[1]), 64'(8'h11));
      chk("t1_head", 64'(head_o), 64'(2));
      chk("t1_count", 64'(count_o), 64'(2));
      done_vec_i[2] = 1'b1;
      tick();
      chk("t1b_data0", 64'(retire_data_o[0]), 64'(8'h12));
      chk("t1b_head", 64'(head_o), 64'(4));
      chk("t1b_empty", 64'(empty_o), 64'(1));

      // Walk the head to 14, then retire a full group across the wrap.
      dispatch(4, 8'h40, 1'b1, 1'b0);
      dispatch(4, 8'h48, 1'b1, 1'b0);
      dispatch(2, 8'h4C, 1'b1, 1'b0);
      tick();
      chk("t2_head14", 64'(head_o), 64'(14));
      chk("t2_count0", 64'(count_o), 64'(0));
      dispatch(4, 8'hA0, 1'b0, 1'b0);
      done_vec_i[14] = 1'b1; done_vec_i[15] = 1'b1; done_vec_i[0] = 1'b1; done_vec_i[1] = 1'b1;
      tick();
      chk("t2_valid", 64'(retire_valid_o), 64'(4'b1111));
      chk("t2_data0", 64'(retire_data_o[0]), 64'(8'hA0));
      chk("t2_data3", 64'(retire_data_o[3]), 64'(8'hA3));
      chk("t2_head_wrap", 64'(head_o), 64'(2));

      // Stalled group holds for three cycles while new done entries queue up.
      dispatch(4, 8'hB0, 1'b0, 1'b0);
      for (int s = 2; s < 6; s++) done_vec_i[s] = 1'b1;
      retire_ready_i = 1'b0;
      tick();
      chk("t3_load_valid", 64'(retire_valid_o), 64'(4'b1111));
      chk("t3_load_head", 64'(head_o), 64'(6));
      dispatch(2, 8'hC0, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) tick();
         chk("t3_stall_valid", 64'(retire_valid_o), 64'(4'b1111));
         chk("t3_stall_data0", 64'(retire_data_o[0]), 64'(8'hB0));
         chk("t3_stall_data3", 64'(retire_data_o[3]), 64'(8'hB3));
         chk("t3_stall_head", 64'(head_o), 64'(6));
         chk("t3_stall_count", 64'(count_o), 64'(2));
      end
      retire_ready_i = 1'b1;
      tick();
      chk("t3_accept_valid", 64'(retire_valid_o), 64'(4'b0011));
      chk("t3_accept_data0", 64'(retire_data_o[0]), 64'(8'hC0));
      chk("t3_accept_head", 64'(head_o), 64'(8));

      // Faulted head behind a stalled group: pulse only after the group drains.
      retire_ready_i = 1'b0;
      dispatch(1, 8'hE5, 1'b1, 1'b1);
      tick();
      chk("t4_hold_valid", 64'(retire_valid_o), 64'(4'b0011));
      chk("t4_no_exc_a", 64'(exception_o), 64'(0));
      tick();
      chk("t4_no_exc_b", 64'(exception_o), 64'(0));
      chk("t4_wait_head", 64'(head_o), 64'(8));
      retire_ready_i = 1'b1;
      tick();
      chk("t4_exc", 64'(exception_o), 64'(1));
      chk("t4_exc_data", 64'(exc_data_o), 64'(8'hE5));
      chk("t4_valid_clr", 64'(retire_valid_o), 64'(0));
      tick();
      chk("t4_flush_exc", 64'(exception_o), 64'(0));
      chk("t4_flush_head", 64'(head_o), 64'(0));
      chk("t4_flush_count", 64'(count_o), 64'(0));
      tail = 0;
      done_vec_i = '0;
      exc_vec_i = '0;

      // Overflow from 14 with three more and nothing retiring.
      dispatch(4, 8'h50, 1'b0, 1'b0);
      dispatch(4, 8'h54, 1'b0, 1'b0);
      dispatch(4, 8'h58, 1'b0, 1'b0);
      dispatch(2, 8'h5C, 1'b0, 1'b0);
      chk("t5_count14", 64'(count_o), 64'(14));
      chk("t5_no_ovf", 64'(ovf_o), 64'(0));
      dispatch(3, 8'h60, 1'b0, 1'b0);
      chk("t5_ovf", 64'(ovf_o), 64'(1));
      chk("t5_count16", 64'(count_o), 64'(16));
      chk("t5_full", 64'(full_o), 64'(1));
      done_vec_i[0] = 1'b1; done_vec_i[3] = 1'b1;
      dispatch(2, 8'h70, 1'b1, 1'b0);
      chk("t5_full_retire_count", 64'(count_o), 64'(14));
      chk("t5_full_retire_head", 64'(head_o), 64'(4));
      chk("t5_ovf_sticky", 64'(ovf_o), 64'(1));

      // Reset while in EXCEPT suppresses the pulse.
      done_vec_i[4] = 1'b1; exc_vec_i[4] = 1'b1;
      tick();
      chk("t6_pre_exc", 64'(exception_o), 64'(0));
      reset_n = 1'b0;
      tick();
      chk_reset_vals("t6_reset");
      reset_n = 1'b1;
      done_vec_i = '0;
      exc_vec_i = '0;
      tick();
      chk("t6_after_exc", 64'(exception_o), 64'(0));
      chk("t6_after_head", 64'(head_o), 64'(0));
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
